// File: rtl/pdp_pkg.sv
// Shared types for the PDP-8 execution stage: decoded opcode bundles,
// execution FSM states and the reset PC.
package pdp_pkg;

  localparam int unsigned PDP_ADDR_W     = 12;
  localparam int unsigned PDP_DATA_W     = 12;
  localparam logic [11:0] PDP_START_ADDR = 12'o200;

  typedef struct packed {
    logic        and_op;
    logic        tad;
    logic        isz;
    logic        dca;
    logic        jms;
    logic        jmp;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic cla;
    logic cll;
    logic cma;
    logic cml;
    logic iac;
    logic rar;
    logic ral;
    logic rtr;
    logic rtl;
    logic hlt;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_DONE,
    ST_HALT
  } exec_state_e;

  typedef enum logic [2:0] {
    OP_AND,
    OP_TAD,
    OP_ISZ,
    OP_DCA,
    OP_JMS,
    OP_JMP,
    OP_OP7
  } exec_op_e;

endpackage

// File: rtl/pdp_op7_alu.sv
// Combinational group-1 operate microinstruction unit acting on {link,ac}:
// clear, complement, increment, then rotate.
module pdp_op7_alu
  import pdp_pkg::*;
#(
  parameter int unsigned DATA_W = PDP_DATA_W
) (
  input  logic [DATA_W:0]  link_ac_in,
  input  pdp_op7_opcode_s  op7,
  output logic [DATA_W:0]  link_ac_out
);

  logic [DATA_W:0] v;

  always_comb begin
    v = link_ac_in;
    // A halting op7 is sequenced by the FSM and leaves AC/LINK untouched.
    if (!op7.hlt) begin
      if (op7.cla) v[DATA_W-1:0] = '0;
      if (op7.cll) v[DATA_W]     = 1'b0;
      if (op7.cma) v[DATA_W-1:0] = ~v[DATA_W-1:0];
      if (op7.cml) v[DATA_W]     = ~v[DATA_W];
      if (op7.iac) v = v + (DATA_W+1)'(1);
      if (op7.rar) v = {v[0], v[DATA_W:1]};
      if (op7.ral) v = {v[DATA_W-1:0], v[DATA_W]};
      if (op7.rtr) v = {v[1:0], v[DATA_W:2]};
      if (op7.rtl) v = {v[DATA_W-2:0], v[DATA_W:DATA_W-1]};
    end
    link_ac_out = v;
  end

endmodule

// File: rtl/pdp_exec_unit.sv
// PDP-8 execution stage: memory-reference and group-1 operate instructions
// against AC/LINK. Optional EXEC_INSTR_COUNT_EN adds a retired-instruction counter.
module pdp_exec_unit
  import pdp_pkg::*;
#(
  parameter int unsigned           ADDR_W     = PDP_ADDR_W,
  parameter int unsigned           DATA_W     = PDP_DATA_W,
  parameter logic [ADDR_W-1:0]     START_ADDR = ADDR_W'(PDP_START_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  pdp_mem_opcode_s   pdp_mem_opcode,
  input  pdp_op7_opcode_s   pdp_op7_opcode,
  output logic              stall,
  output logic [ADDR_W-1:0] PC_value,
  output logic              exec_rd_req,
  output logic [ADDR_W-1:0] exec_rd_addr,
  input  logic [DATA_W-1:0] exec_rd_data,
  output logic              exec_wr_req,
  output logic [ADDR_W-1:0] exec_wr_addr,
  output logic [DATA_W-1:0] exec_wr_data,
  output logic [DATA_W-1:0] ac,
  output logic              link
`ifdef EXEC_INSTR_COUNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  exec_state_e      state;
  exec_op_e         op;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] md_inc;
  pdp_op7_opcode_s  op7_q;
  logic [DATA_W:0]  alu_out;
  logic             mem_any;
  logic             op7_any;

  always_comb begin
    mem_any = pdp_mem_opcode.and_op | pdp_mem_opcode.tad | pdp_mem_opcode.isz |
              pdp_mem_opcode.dca | pdp_mem_opcode.jms | pdp_mem_opcode.jmp;
    op7_any = |pdp_op7_opcode;
  end

  pdp_op7_alu #(.DATA_W(DATA_W)) u_op7_alu (
    .link_ac_in  ({link, ac}),
    .op7         (op7_q),
    .link_ac_out (alu_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      op           <= OP_JMP;
      ea           <= '0;
      pc           <= '0;
      md_inc       <= '0;
      op7_q        <= '0;
      stall        <= 1'b0;
      PC_value     <= START_ADDR;
      exec_rd_req  <= 1'b0;
      exec_rd_addr <= '0;
      exec_wr_req  <= 1'b0;
      exec_wr_addr <= '0;
      exec_wr_data <= '0;
      ac           <= '0;
      link         <= 1'b0;
`ifdef EXEC_INSTR_COUNT_EN
      instr_count  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_any || op7_any) begin
            ea    <= pdp_mem_opcode.mem_inst_addr;
            pc    <= base_addr;
            op7_q <= pdp_op7_opcode;
            stall <= 1'b1;
            // Strobes are registered, so they are raised on entry to RD/WR.
            if (pdp_mem_opcode.and_op || pdp_mem_opcode.tad || pdp_mem_opcode.isz) begin
              op           <= pdp_mem_opcode.and_op ? OP_AND :
                              pdp_mem_opcode.tad    ? OP_TAD : OP_ISZ;
              exec_rd_req  <= 1'b1;
              exec_rd_addr <= pdp_mem_opcode.mem_inst_addr;
              state        <= ST_RD;
            end else if (pdp_mem_opcode.dca || pdp_mem_opcode.jms) begin
              op           <= pdp_mem_opcode.dca ? OP_DCA : OP_JMS;
              exec_wr_req  <= 1'b1;
              exec_wr_addr <= pdp_mem_opcode.mem_inst_addr;
              exec_wr_data <= pdp_mem_opcode.dca ? ac : DATA_W'(base_addr + ADDR_W'(1));
              state        <= ST_WR;
            end else if (pdp_mem_opcode.jmp) begin
              op    <= OP_JMP;
              state <= ST_DONE;
            end else if (pdp_op7_opcode.hlt) begin
              op       <= OP_OP7;
              PC_value <= base_addr + ADDR_W'(1);
              state    <= ST_HALT;
`ifdef EXEC_INSTR_COUNT_EN
              instr_count <= instr_count + 32'd1;
`endif
            end else begin
              op    <= OP_OP7;
              state <= ST_DONE;
            end
          end
        end
        ST_RD: begin
          exec_rd_req <= 1'b0;
          state       <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          case (op)
            OP_AND: begin
              ac    <= ac & exec_rd_data;
              state <= ST_DONE;
            end
            OP_TAD: begin
              {link, ac} <= {link, ac} + {1'b0, exec_rd_data};
              state      <= ST_DONE;
            end
            default: begin
              md_inc       <= exec_rd_data + DATA_W'(1);
              exec_wr_req  <= 1'b1;
              exec_wr_addr <= ea;
              exec_wr_data <= exec_rd_data + DATA_W'(1);
              state        <= ST_WR;
            end
          endcase
        end
        ST_WR: begin
          exec_wr_req <= 1'b0;
          if (op == OP_DCA) ac <= '0;
          state <= ST_DONE;
        end
        ST_DONE: begin
          stall <= 1'b0;
          state <= ST_IDLE;
          case (op)
            OP_JMP:  PC_value <= ea;
            OP_JMS:  PC_value <= ea + ADDR_W'(1);
            OP_ISZ:  PC_value <= (md_inc == '0) ? pc + ADDR_W'(2) : pc + ADDR_W'(1);
            default: PC_value <= pc + ADDR_W'(1);
          endcase
          if (op == OP_OP7) {link, ac} <= alu_out;
`ifdef EXEC_INSTR_COUNT_EN
          instr_count <= instr_count + 32'd1;
`endif
        end
        ST_HALT: begin
          stall <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp_exec_unit.sv
// Directed, table-driven bench for pdp_exec_unit with a behavioural memory,
// plus hand-written reset-abort and halt sequences.
module tb_pdp_exec_unit;
  import pdp_pkg::*;

  localparam int T_AND = 0, T_TAD = 1, T_ISZ = 2, T_DCA = 3, T_JMS = 4, T_JMP = 5, T_OP7 = 6;
  localparam logic [9:0] CLA = 10'b1000000000, CLL = 10'b0100000000, CMA = 10'b0010000000,
                         CML = 10'b0001000000, IAC = 10'b0000100000, RAR = 10'b0000010000,
                         RAL = 10'b0000001000, RTR = 10'b0000000100, RTL = 10'b0000000010,
                         HLT = 10'b0000000001;
  localparam int NV = 16;

  typedef struct {
    int          op;
    logic [11:0] ea;
    logic [11:0] base;
    logic [9:0]  o7;
    bit          pre;
    logic [11:0] pre_addr;
    logic [11:0] pre_data;
    logic [11:0] exp_ac;
    logic        exp_link;
    logic [11:0] exp_pc;
    int          exp_lat;
    bit          exp_wr;
    logic [11:0] exp_wa;
    logic [11:0] exp_wd;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [11:0]     base_addr = '0;
  pdp_mem_opcode_s mop = '0;
  pdp_op7_opcode_s o7op = '0;
  logic            stall;
  logic [11:0]     PC_value;
  logic            exec_rd_req;
  logic [11:0]     exec_rd_addr;
  logic [11:0]     exec_rd_data;
  logic            exec_wr_req;
  logic [11:0]     exec_wr_addr;
  logic [11:0]     exec_wr_data;
  logic [11:0]     ac;
  logic            link;
`ifdef EXEC_INSTR_COUNT_EN
  logic [31:0]     instr_count;
`endif

  pdp_exec_unit #(.START_ADDR(12'o200)) dut (
    .clk            (clk),
    .reset          (reset),
    .base_addr      (base_addr),
    .pdp_mem_opcode (mop),
    .pdp_op7_opcode (o7op),
    .stall          (stall),
    .PC_value       (PC_value),
    .exec_rd_req    (exec_rd_req),
    .exec_rd_addr   (exec_rd_addr),
    .exec_rd_data   (exec_rd_data),
    .exec_wr_req    (exec_wr_req),
    .exec_wr_addr   (exec_wr_addr),
    .exec_wr_data   (exec_wr_data),
    .ac             (ac),
    .link           (link)
`ifdef EXEC_INSTR_COUNT_EN
    ,
    .instr_count    (instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural memory: one-cycle read latency, write on strobe, preload port.
  logic [11:0] mem [0:4095];
  logic        pl_req = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [11:0] pl_data = '0;
  int          wr_cnt = 0;
  logic [11:0] last_wa = '0;
  logic [11:0] last_wd = '0;
  bit          overlap = 1'b0;

  always @(posedge clk) begin
    if (pl_req) mem[pl_addr] <= pl_data;
    if (exec_rd_req) exec_rd_data <= mem[exec_rd_addr];
    if (exec_wr_req) begin
      mem[exec_wr_addr] <= exec_wr_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= exec_wr_addr;
      last_wd <= exec_wr_data;
    end
    if (exec_rd_req && exec_wr_req) overlap <= 1'b1;
  end

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [11:0] ea, input logic [11:0] base,
                              input logic [9:0] o7, input bit pre, input logic [11:0] pa,
                              input logic [11:0] pd, input logic [11:0] eac, input logic el,
                              input logic [11:0] epc, input int lat, input bit ew,
                              input logic [11:0] ewa, input logic [11:0] ewd);
    vec_t v;
    v.op = op; v.ea = ea; v.base = base; v.o7 = o7; v.pre = pre; v.pre_addr = pa;
    v.pre_data = pd; v.exp_ac = eac; v.exp_link = el; v.exp_pc = epc; v.exp_lat = lat;
    v.exp_wr = ew; v.exp_wa = ewa; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_req = 1'b1;
    @(negedge clk);
    pl_req = 1'b0;
  endtask

  task automatic drive(input int op, input logic [11:0] ea, input logic [11:0] base,
                       input logic [9:0] o7);
    @(negedge clk);
    mop = '0;
    o7op = '0;
    base_addr = base;
    mop.mem_inst_addr = ea;
    case (op)
      T_AND:   mop.and_op = 1'b1;
      T_TAD:   mop.tad = 1'b1;
      T_ISZ:   mop.isz = 1'b1;
      T_DCA:   mop.dca = 1'b1;
      T_JMS:   mop.jms = 1'b1;
      T_JMP:   mop.jmp = 1'b1;
      default: o7op = pdp_op7_opcode_s'(o7);
    endcase
    @(posedge clk); #1;
    mop = '0;
    o7op = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int wr0;
    if (v.pre) preload(v.pre_addr, v.pre_data);
    wr0 = wr_cnt;
    drive(v.op, v.ea, v.base, v.o7);
    n = 0;
    while (stall && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d latency", idx), n + 1, v.exp_lat);
    chk($sformatf("v%0d ac", idx), {20'd0, ac}, {20'd0, v.exp_ac});
    chk($sformatf("v%0d link", idx), {31'd0, link}, {31'd0, v.exp_link});
    chk($sformatf("v%0d pc", idx), {20'd0, PC_value}, {20'd0, v.exp_pc});
    chk($sformatf("v%0d writes", idx), wr_cnt - wr0, v.exp_wr ? 1 : 0);
    if (v.exp_wr) begin
      chk($sformatf("v%0d wr_addr", idx), {20'd0, last_wa}, {20'd0, v.exp_wa});
      chk($sformatf("v%0d wr_data", idx), {20'd0, last_wd}, {20'd0, v.exp_wd});
    end
  endtask

  initial begin
    int  wr0;
    bit  dropped;

    vecs[0]  = mk(T_TAD, 12'o50,  12'o100,  '0,        1, 12'o50, 12'o7777, 12'o7777, 1'b0, 12'o101, 4, 0, '0, '0);
    vecs[1]  = mk(T_TAD, 12'o50,  12'o101,  '0,        0, '0, '0,           12'o7776, 1'b1, 12'o102, 4, 0, '0, '0);
    vecs[2]  = mk(T_AND, 12'o70,  12'o102,  '0,        1, 12'o70, 12'o0707, 12'o0706, 1'b1, 12'o103, 4, 0, '0, '0);
    vecs[3]  = mk(T_ISZ, 12'o60,  12'o300,  '0,        1, 12'o60, 12'o7777, 12'o0706, 1'b1, 12'o302, 5, 1, 12'o60, 12'o0000);
    vecs[4]  = mk(T_ISZ, 12'o60,  12'o300,  '0,        1, 12'o60, 12'o0005, 12'o0706, 1'b1, 12'o301, 5, 1, 12'o60, 12'o0006);
    vecs[5]  = mk(T_OP7, '0,      12'o301,  CLA | CLL, 0, '0, '0,           12'o0000, 1'b0, 12'o302, 2, 0, '0, '0);
    vecs[6]  = mk(T_TAD, 12'o71,  12'o302,  '0,        1, 12'o71, 12'o1234, 12'o1234, 1'b0, 12'o303, 4, 0, '0, '0);
    vecs[7]  = mk(T_DCA, 12'o72,  12'o303,  '0,        0, '0, '0,           12'o0000, 1'b0, 12'o304, 3, 1, 12'o72, 12'o1234);
    vecs[8]  = mk(T_JMS, 12'o400, 12'o210,  '0,        0, '0, '0,           12'o0000, 1'b0, 12'o401, 3, 1, 12'o400, 12'o211);
    vecs[9]  = mk(T_OP7, '0,      12'o401,  CLA | CMA | IAC, 0, '0, '0,     12'o0000, 1'b1, 12'o402, 2, 0, '0, '0);
    vecs[10] = mk(T_OP7, '0,      12'o402,  IAC,       0, '0, '0,           12'o0001, 1'b1, 12'o403, 2, 0, '0, '0);
    vecs[11] = mk(T_OP7, '0,      12'o403,  RAR,       0, '0, '0,           12'o4000, 1'b1, 12'o404, 2, 0, '0, '0);
    vecs[12] = mk(T_OP7, '0,      12'o404,  RTL,       0, '0, '0,           12'o0003, 1'b0, 12'o405, 2, 0, '0, '0);
    vecs[13] = mk(T_OP7, '0,      12'o405,  CMA | CML, 0, '0, '0,           12'o7774, 1'b1, 12'o406, 2, 0, '0, '0);
    vecs[14] = mk(T_OP7, '0,      12'o406,  RTR,       0, '0, '0,           12'o3777, 1'b0, 12'o407, 2, 0, '0, '0);
    vecs[15] = mk(T_JMP, 12'o0,   12'o7777, '0,        0, '0, '0,           12'o3777, 1'b0, 12'o0000, 2, 0, '0, '0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset pc", {20'd0, PC_value}, 32'o200);
    chk("reset ac", {20'd0, ac}, 32'd0);
    chk("reset link", {31'd0, link}, 32'd0);
    chk("reset strobes", {30'd0, exec_rd_req, exec_wr_req}, 32'd0);

    // Load AC, then abort a TAD while it waits for read data.
    run_vec(mk(T_OP7, '0, 12'o200, CMA, 0, '0, '0, 12'o7777, 1'b0, 12'o201, 2, 0, '0, '0), 99);
    preload(12'o50, 12'o7777);
    drive(T_TAD, 12'o50, 12'o201, '0);
    chk("tad stall raised", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort stall", {31'd0, stall}, 32'd0);
    chk("abort pc", {20'd0, PC_value}, 32'o200);
    chk("abort ac", {20'd0, ac}, 32'd0);
    wr0 = wr_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort no write", wr_cnt - wr0, 0);
    chk("abort idle stall", {31'd0, stall}, 32'd0);
`ifdef EXEC_INSTR_COUNT_EN
    chk("abort count", instr_count, 32'd0);
`endif

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

`ifdef EXEC_INSTR_COUNT_EN
    chk("count before halt", instr_count, NV);
`endif

    drive(T_OP7, '0, 12'o0, HLT);
`ifdef EXEC_INSTR_COUNT_EN
    chk("count at halt", instr_count, NV + 1);
`endif
    dropped = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (!stall) dropped = 1'b1;
    end
    chk("halt stall held", {31'd0, dropped}, 32'd0);
    chk("halt pc", {20'd0, PC_value}, 32'o1);
`ifdef EXEC_INSTR_COUNT_EN
    chk("count after halt", instr_count, NV + 1);
`endif
    chk("rd/wr overlap", {31'd0, overlap}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pdp_exec_unit.md
Name: pdp_exec_unit

Overview:
- Execution stage directly downstream of instr_decode.
- Consumes base_addr, pdp_mem_opcode and pdp_op7_opcode.
- Executes PDP-8 memory-reference instructions and group-1 operate microinstructions against AC/LINK.
- Drives stall and PC_value back to instruction decode, and owns a separate read/write port to memory.

Parameters:
- START_ADDR, 'o200, PC_value after reset.
- ADDR_W, `ADDR_WIDTH (12), address width.
- DATA_W, `DATA_WIDTH (12), data width.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- base_addr  in  ADDR_W  address of the decoded instruction.
- pdp_mem_opcode  in  pdp_mem_opcode_s  one-hot and_op/tad/isz/dca/jms/jmp plus mem_inst_addr[11:0], the effective address already resolved by IFD.
- pdp_op7_opcode  in  pdp_op7_opcode_s  cla/cll/cma/cml/iac/rar/ral/rtr/rtl/hlt bits.
- stall  out  1  execution busy; IFD must hold and not fetch.
- PC_value  out  ADDR_W  next instruction address.
- exec_rd_req  out  1  memory read strobe.
- exec_rd_addr  out  ADDR_W  read address.
- exec_rd_data  in  DATA_W  read data, valid the cycle after exec_rd_req.
- exec_wr_req  out  1  single-cycle write strobe.
- exec_wr_addr  out  ADDR_W  write address.
- exec_wr_data  out  DATA_W  write data.
- ac  out  DATA_W  accumulator (observability).
- link  out  1  link bit.

Behaviour:
- Reset values (asynchronous): stall=0, PC_value=START_ADDR, ac=0, link=0, all req=0, addr/data=0, state IDLE.
- Reset mid-instruction aborts the instruction; no write is issued after reset deasserts.
- State machine: IDLE, RD, RD_WAIT, WR, DONE, HALT.
- IDLE:
  - Sample the inputs when any opcode bit is set.
  - Latch ea=mem_inst_addr and pc=base_addr.
  - Set stall=1 on the same edge.
  - AND/TAD/ISZ go to RD. DCA/JMS go to WR. JMP and op7 go to DONE.
  - op7 with hlt goes to HALT.
  - No opcode bits set: remain in IDLE with stall=0.
- RD: exec_rd_req=1 and exec_rd_addr=ea for one cycle; go to RD_WAIT.
- RD_WAIT: capture exec_rd_data as md.
  - AND: ac&=md.
  - TAD: {link,ac}+=md, 13-bit add; carry complements link.
  - ISZ: md+1 mod 2^12, then go to WR.
  - AND/TAD go to DONE.
- WR: exec_wr_req=1 for exactly one cycle.
  - DCA: data=ac, then ac=0.
  - JMS: addr=ea, data=pc+1.
  - ISZ: data=md+1.
  - Go to DONE.
- DONE: update PC_value, set stall=0, go to IDLE.
  - JMP: PC=ea.
  - JMS: PC=ea+1.
  - ISZ: PC=pc+2 if the incremented value is 0, else pc+1.
  - All others: PC=pc+1.
  - All PC arithmetic wraps modulo 2^12, e.g. 'o7777+1='o0000.
- op7 sequence, applied in DONE, all selected bits combine:
  1. cla/cll
  2. cma/cml
  3. iac (carry complements link)
  4. rotate of the 13-bit {link,ac}: rar/ral by 1, rtr/rtl by 2.
- HALT: stall held 1, PC_value=pc+1; leave only via reset.
- Latencies (capture to stall release):
  - JMP/op7: 2 cycles.
  - DCA/JMS: 3 cycles.
  - AND/TAD: 4 cycles.
  - ISZ: 5 cycles.
- exec_rd_req and exec_wr_req are never asserted in the same cycle.

Optional Feature:
- Macro EXEC_INSTR_COUNT_EN.
- When defined: adds output instr_count[31:0]. It increments by 1 on each DONE and on entry to HALT, resets to 0, and wraps at 2^32.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pdp_pkg holds:
  - pdp_mem_opcode_s and pdp_op7_opcode_s;
  - the exec state enum;
  - the START_ADDR default, 'o200.
- One natural sub-module, pdp_op7_alu: purely combinational, takes {link,ac} and pdp_op7_opcode, returns the new {link,ac}.
- The FSM and memory port stay in pdp_exec_unit.

Test Plan:
- Reset during RD_WAIT of TAD -> stall=0, PC='o200, ac=0; no exec_wr_req afterwards.
- ac=0, mem['o50]='o7777, TAD ea='o50, then TAD 'o50 again:
  - after the first: ac='o7777, link=0;
  - after the second: ac='o7776, link=1.
- ISZ ea='o60 with mem='o7777 at base 'o300 -> write 'o0000 to 'o60, PC='o302, 5-cycle stall. With mem='o0005 -> write 'o0006, PC='o301.
- JMS ea='o400 at base 'o210 -> write 'o211 to 'o400, PC='o401.
- DCA with ac='o1234 -> write 'o1234, then ac=0.
- op7 cla+cma+iac with link=0 -> ac=0, link=1.
- JMP at base 'o7777 to 'o0 -> PC='o0. Then op7 hlt -> stall stays 1 for 100 cycles; with EXEC_INSTR_COUNT_EN, instr_count increments by 1.
